dmem_responder: RTL
===================

# dmem_responder

Responder end of the CPU data-memory interface: a word-addressed data RAM behind a valid/ready request channel and a valid/ready response channel, with a fixed, parameterised access latency. It replaces the zero-wait data memory on the MEM-stage side, so the pipeline can later be stalled on real memory latency. It holds at most one outstanding request, performs loads and stores, and flags misaligned or out-of-range accesses.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two, ≥ 4.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid_o`; must be ≥ 1.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  responder can accept a request.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data.
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  requester takes the response.
- `resp_rdata_o`  out  32  load data; 0 for stores and errors.
- `resp_err_o`  out  1  access was misaligned or out of range.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: `req_ready_o`=1. When `req_valid_i` is 1, the request is accepted and write, address and wdata are latched. The FSM moves to BUSY with counter = LATENCY-1. If LATENCY=1, it moves directly to RESP.
- BUSY: `req_ready_o`=0. The counter decrements each cycle. When the counter reaches 0:
  - A load reads the array.
  - A store writes the array.
  - The FSM moves to RESP.
- RESP: `resp_valid_o`=1. Data and err are stable until `resp_ready_i`=1. On that handshake the FSM returns to IDLE.
- Word index = addr[31:2]. An access is an error if addr[1:0]≠0 or index ≥ DEPTH_WORDS.
  - Error loads return rdata=0 and err=1.
  - Error stores do not write, and return err=1.
- A store response has rdata=0 and err=0 when the store is legal.
- Inputs are sampled only on the acceptance cycle. Changes to inputs while BUSY or RESP are ignored.
- `req_ready_o` depends only on state. There is no combinational path from `req_valid_i` to `req_ready_o`, or from `resp_ready_i` to `resp_valid_o`.
- Reset:
  - FSM goes to IDLE; counter, latched request, `resp_rdata_o` and `resp_err_o` clear to 0.
  - Array contents are not reset.
- Reset in BUSY drops the request. A store whose counter has not reached 0 is not committed.
- Reset in RESP discards the pending response.
- Reset has priority over every handshake in the same cycle.

## Timing
- Reset values: `req_ready_o`=1 from the first cycle after reset; `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0.
- Accept in cycle T: `resp_valid_o`=1 from cycle T+LATENCY.
- Response handshake in cycle R: `req_ready_o`=1 in R+1. The next accept is possible in R+1.
- Maximum throughput: one request per LATENCY+1 cycles, when `resp_ready_i` is held at 1.
- Read-after-write: a store completes before its response, so a load accepted after a store's response observes the stored data.
- Counter width is $clog2(LATENCY+1). Address comparison uses the full 30-bit index, with no truncation before the range check.

## Structure
- Package `dmem_pkg`: state enum (IDLE, BUSY, RESP) and the word/address width constants (32, byte-offset 2).
- Sub-module `dmem_array`: single-port synchronous RAM, DEPTH_WORDS×32. Inputs are en, we, index, wdata; output rdata is registered and valid one cycle after en. The FSM issues the array access in the final BUSY cycle, so for LATENCY=1 the access is issued on the acceptance cycle.
- All handshake and error logic lives in `dmem_responder`.

## Test plan
- Store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF; then load 0x10. Required: store response at T+2 with err=0, rdata=0; load response with rdata=0xDEADBEEF.
- Backpressure: hold `resp_ready_i`=0 for 5 cycles after a load of 0x10. Required: `resp_valid_o` and rdata stay stable and `req_ready_o` stays 0 throughout; handshake on cycle 6, then `req_ready_o`=1 next cycle.
- Errors:
  - Load 0x13 → err=1, rdata=0.
  - Store 0x400 with DEPTH_WORDS=256, data 0x1 → err=1; the array is unchanged, so a load of 0x0 still returns its prior value.
- LATENCY=1 back-to-back with `resp_ready_i`=1: three loads. Required: accepts in cycles 0, 2 and 4; responses in cycles 1, 3 and 5.
- Reset mid-BUSY, LATENCY=4: store 0x20 := 0xA5A5A5A5 over old 0x11111111, with reset asserted in cycle T+1. Required: no response; a later load of 0x20 returns 0x11111111.
- Input churn: change addr and wdata every cycle while BUSY. Required: the response reflects only the values latched at acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state type, the word/address widths and the access-fault helper.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int OFFS_W = 2;
  localparam int IDX_FULL_W = ADDR_W - OFFS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Fault if not word aligned or the full 30-bit word index is out of range.
  function automatic logic addr_err(
    input logic [ADDR_W-1:0] addr,
    input int                depth
  );
    logic [IDX_FULL_W-1:0] idx;
    logic [ADDR_W-1:0]     lim;
    idx = addr[ADDR_W-1:OFFS_W];
    lim = 32'(depth);
    return (addr[OFFS_W-1:0] != '0) ||
           ({{OFFS_W{1'b0}}, idx} >= lim);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, DEPTH_WORDS x 32, registered read.
// Ports: clk, en, we, idx, wdata in; rdata out (valid the cycle after en).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed access latency.
// Ports: clk_i, rst_i, req_{valid_i,ready_o,write_i,addr_i,wdata_i},
//        resp_{valid_o,ready_i,rdata_o,err_o}.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WORD_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;

  logic              accept;
  logic              issue;
  logic              acc_we;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [WORD_W-1:0] arr_rdata;

  assign accept = (state == IDLE) && req_valid_i;

  // With LATENCY=1 the access goes out on the accept cycle,
  // before the request registers hold anything, so use live inputs.
  always_comb begin
    acc_we    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_we    = req_write_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
    end
  end

  // Reset in the access cycle must block a store commit.
  always_comb begin
    issue = 1'b0;
    if (!rst_i) begin
      unique case (1'b1)
        (state == IDLE): issue = accept && (LATENCY == 1);
        (state == BUSY): issue = (cnt == CNT_LAST);
        default:         issue = 1'b0;
      endcase
    end
  end

  assign acc_err = addr_err(acc_addr, DEPTH_WORDS);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk_i),
    .en   (issue && !acc_err),
    .we   (acc_we),
    .idx  (acc_addr[IDX_W+OFFS_W-1:OFFS_W]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wr_q    <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (issue) err_q <= acc_err;
    end
  end

  // Array output only moves on an access, so it holds through RESP.
  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == RESP);
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !wr_q && !err_q)
                      ? arr_rdata : '0;

endmodule
